// File: rtl/pipeline_pkg.sv
// Shared types and widths for the IF/ID boundary stage.
package pipeline_pkg;

  localparam int unsigned INSTR_W = 24;
  localparam int unsigned PC_W    = INSTR_W - 8;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic {
    RUN    = 1'b0,
    REPLAY = 1'b1
  } fdb_state_t;

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch/execute/decode handshake bundle around the IF/ID buffer.
//   fInstruction  : instruction presented by fetch this cycle
//   branchTaken   : execute redirect request, branchTarget its target
//   idReady       : decode accepts idInstruction at this edge
//   pcWrEn/newPc  : redirect request/target back to fetch
//   idValid/idInstruction/idPc : buffered instruction to decode
interface fetch_decode_buffer_if;
  import pipeline_pkg::*;

  logic [INSTR_W-1:0] fInstruction;
  logic               branchTaken;
  logic [PC_W-1:0]    branchTarget;
  logic               idReady;
  logic               pcWrEn;
  logic [PC_W-1:0]    newPc;
  logic               idValid;
  logic [INSTR_W-1:0] idInstruction;
  logic [PC_W-1:0]    idPc;

  // Environment side: fetch, execute and decode.
  modport master (
    output fInstruction, branchTaken, branchTarget, idReady,
    input  pcWrEn, newPc, idValid, idInstruction, idPc
  );

  // Buffer side.
  modport slave (
    input  fInstruction, branchTaken, branchTarget, idReady,
    output pcWrEn, newPc, idValid, idInstruction, idPc
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk, rst_n : clock, async active-low reset
//   i_en       : increment this cycle
//   o_count    : current count
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_decode_buffer.sv
// IF/ID buffer: captures fetch's instruction with its PC, holds it for decode,
// and redirects fetch to replay anything it cannot accept or to a branch target.
//   clk, reset  : clock, async active-low reset
//   bus         : fetch/execute/decode handshake (slave side)
//   replaying   : a replay redirect is outstanding
//   stallCycles : saturating count of replay redirects
//   flushCount  : saturating count of branch flushes
module fetch_decode_buffer
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  fetch_decode_buffer_if.slave  bus,
  output logic                  replaying,
  output logic [CNT_W-1:0]      stallCycles,
  output logic [CNT_W-1:0]      flushCount
);

  fdb_state_t         r_state;
  fdb_state_t         w_state_nxt;

  logic [PC_W-1:0]    r_addr;
  logic               r_wr_en;
  logic [PC_W-1:0]    r_new_pc;
  logic [PC_W-1:0]    w_fetch_addr;

  logic               r_id_valid;
  logic [INSTR_W-1:0] r_id_instr;
  logic [PC_W-1:0]    r_id_pc;

  logic               w_cap;
  logic               w_stall;
  logic               w_pc_wr_en;

  // Address of the instruction fetch is presenting right now.
  assign w_fetch_addr = r_wr_en ? r_new_pc : (r_addr + PC_W'(PC_STEP));

  // Branch always wins; otherwise accept when the slot is empty or draining.
  assign w_cap   = !bus.branchTaken && (!r_id_valid || bus.idReady);
  assign w_stall = !w_cap && !bus.branchTaken;

  // Shadow copy of fetch's PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_addr  <= w_fetch_addr;
      r_wr_en <= w_pc_wr_en;
    end
  end

  // Redirect target: branch target, else the address being dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_new_pc <= '0;
    end else if (bus.branchTaken) begin
      r_new_pc <= bus.branchTarget;
    end else if (w_stall) begin
      r_new_pc <= w_fetch_addr;
    end
  end

  // Decode-facing output register; a branch empties it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
    end else if (w_cap) begin
      r_id_valid <= 1'b1;
      r_id_instr <= bus.fInstruction;
      r_id_pc    <= w_fetch_addr;
    end else if (bus.branchTaken) begin
      r_id_valid <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: any stall (re)enters REPLAY, capture or branch leaves it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (w_stall) w_state_nxt = REPLAY;
      REPLAY:  if (!w_stall) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // FSM outputs; the redirect is gated by reset so it drops without a clock.
  always_comb begin
    w_pc_wr_en = 1'b0;
    replaying  = 1'b0;
    if (reset) begin
      w_pc_wr_en = !w_cap;
    end
    if (r_state == REPLAY) begin
      replaying = 1'b1;
    end
  end

  assign bus.pcWrEn        = w_pc_wr_en;
  assign bus.newPc         = r_new_pc;
  assign bus.idValid       = r_id_valid;
  assign bus.idInstruction = r_id_instr;
  assign bus.idPc          = r_id_pc;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_stall),
    .o_count (stallCycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (bus.branchTaken),
    .o_count (flushCount)
  );

endmodule

// File: doc/fetch_decode_buffer.md
# fetch_decode_buffer

IF/ID boundary stage sitting directly downstream of the fetch stage. It captures the instruction that fetch presents each cycle, tags it with its PC, and holds it for decode under a valid/ready handshake. Fetch cannot stall, so every instruction this block cannot accept is dropped and re-fetched through fetch's PC-redirect port (`pcWrEn`/`newPc`). The same port carries taken-branch redirects from execute, which also flush the buffered instruction.

## Interface
- `instructionSize`, 24, instruction width; PC width `PC_W = instructionSize-8` (16).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `fInstruction`  in  `instructionSize`  instruction presented by fetch this cycle.
- `branchTaken`  in  1  execute requests redirect this cycle.
- `branchTarget`  in  `PC_W`  redirect target, valid with `branchTaken`.
- `idReady`  in  1  decode accepts `idInstruction` at this edge.
- `pcWrEn`  out  1  combinational redirect request to fetch.
- `newPc`  out  `PC_W`  registered redirect target to fetch.
- `idValid`  out  1  output register holds a live instruction.
- `idInstruction`  out  `instructionSize`  buffered instruction.
- `idPc`  out  `PC_W`  address of `idInstruction`.
- `replaying`  out  1  FSM in REPLAY.
- `stallCycles`  out  16  saturating count of replay redirects.
- `flushCount`  out  16  saturating count of branch flushes.

## Operation
- Shadow PC mirrors fetch exactly: `fetchAddr = wrEnQ ? newPcQ : addrQ+4` (mod 2^PC_W); `addrQ <= fetchAddr`; `wrEnQ <= pcWrEn`. `fetchAddr` is the address of `fInstruction`.
- Fetch consumes `newPc` in the cycle **after** `pcWrEn`, so `newPc` is the register `newPcQ`, loaded on every cycle `pcWrEn=1` and held otherwise.
- Capture condition: `cap = !branchTaken && (!idValid || idReady)`.
  - `cap`: `idValid<=1`, `idInstruction<=fInstruction`, `idPc<=fetchAddr`.
  - `!cap && branchTaken`: `idValid<=0`, `pcWrEn=1`, `newPcQ<=branchTarget`, `flushCount++`.
  - Otherwise (stall): `pcWrEn=1`, `newPcQ<=fetchAddr` (replay the dropped address), `stallCycles++`.
  - `idValid && idReady && !cap` only occurs with branch; the held instruction is discarded.
- Branch has priority over stall and over a pending replay; the replay target is overwritten.
- FSM states: RUN and REPLAY.
  - RUN→REPLAY on a stall redirect.
  - REPLAY→RUN on `cap` or `branchTaken`.
  - REPLAY self-loops while stalled, re-issuing `pcWrEn` each cycle with the same address.
- Counters saturate at 0xFFFF and never wrap.

## Timing
- Reset values: `idValid=0`, `idInstruction=0`, `idPc=0`, `newPc=0`, `pcWrEn=0`, `replaying=0`, counters 0, `addrQ=0`, `wrEnQ=0`. First post-reset `fetchAddr` is 4.
- Capture latency: one cycle from `fInstruction` to `idInstruction`.
- `pcWrEn` is combinational from `idValid`, `idReady` and `branchTaken`. There is no combinational path from `fInstruction`.
- Stall at cycle t (address A dropped): `newPc=A` at t+1. Fetch presents A at t+1. If `idReady=1` at t+1, A is captured at that edge.
- Branch at t: `idValid=0` at t+1. Target instruction is presented at t+1 and captured at that edge.
- Reset mid-REPLAY: returns to RUN and `pcWrEn` deasserts immediately. Fetch is reset on the same line.

## Structure
- `pipeline_pkg`: `PC_W`, `INSTR_W`, `fdb_state_t` enum {RUN, REPLAY}, `PC_STEP=4`.
- One sub-module: `sat_counter` (16-bit, increment enable, active-low async reset), instantiated twice.
- Output register, shadow PC and FSM live in the top module.

## Test plan
- Reset then free-run with `idReady=1`: `idPc` sequence 4, 8, 12… one cycle behind fetch; `pcWrEn` stays 0.
- Single stall: `idReady=0` for one cycle while holding `idPc=8` with A=12 presented → `pcWrEn=1`, `newPc=12` next cycle. Then `idPc=12`; no instruction lost or duplicated; `stallCycles=1`.
- Five-cycle stall → `replaying=1` for five cycles, `newPc` constant, `stallCycles=5`. Stream resumes in order on release.
- `branchTaken` with target 0x0100 while `idValid=1`: `idValid=0` next cycle, then `idPc=0x0100`; `flushCount=1`.
- Branch during REPLAY: target 0x0200 overrides replay address; next captured `idPc=0x0200`; FSM returns to RUN.
- Async `reset` low mid-REPLAY: all outputs zero without a clock edge. After release the stream restarts at `idPc=4`. Force the counter near 0xFFFF and confirm it holds at 0xFFFF.
